// File: rtl/skin_mask_stats.sv
// -----------------------------------------------------------------------------
// skin_mask_stats
//   Thresholds an H/S/V pixel stream against programmable inclusive windows,
//   emits a binary skin mask aligned with the (delayed) video syncs, and
//   accumulates per-frame statistics (skin pixel count and bounding box) that
//   are published on every rising edge of the delayed vsync.
//
// Ports:
//   clk, rst           pixel clock, asynchronous active-high reset
//   ce                 clock enable; every register holds while low
//   H, S, V            pixel from rgb2hsv
//   in_hsync/vsync/de  video timing aligned with H/S/V
//   h/s/v_min/max      inclusive threshold windows (hue window may wrap)
//   mask               8'hFF on skin pixels, 8'h00 otherwise (2-cycle latency)
//   out_hsync/vsync/de timing delayed to match mask
//   skin_count         skin pixels in the last completed frame (saturating)
//   bbox_x0/x1/y0/y1   bounding box of skin pixels in the last frame
//   bbox_valid         last frame contained at least one skin pixel
//   stats_valid        one-cycle pulse when the statistics outputs update
// -----------------------------------------------------------------------------
module skin_mask_stats #(
    parameter int X_W   = 11,
    parameter int Y_W   = 11,
    parameter int CNT_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic [7:0]       H,
    input  logic [7:0]       S,
    input  logic [7:0]       V,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_de,
    input  logic [7:0]       h_min,
    input  logic [7:0]       h_max,
    input  logic [7:0]       s_min,
    input  logic [7:0]       s_max,
    input  logic [7:0]       v_min,
    input  logic [7:0]       v_max,
    output logic [7:0]       mask,
    output logic             out_hsync,
    output logic             out_vsync,
    output logic             out_de,
    output logic [CNT_W-1:0] skin_count,
    output logic [X_W-1:0]   bbox_x0,
    output logic [X_W-1:0]   bbox_x1,
    output logic [Y_W-1:0]   bbox_y0,
    output logic [Y_W-1:0]   bbox_y1,
    output logic             bbox_valid,
    output logic             stats_valid
);

    localparam logic [X_W-1:0]   X_ONE   = {{(X_W-1){1'b0}}, 1'b1};
    localparam logic [Y_W-1:0]   Y_ONE   = {{(Y_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // stage 1
    logic [7:0] r1_h, r1_s, r1_v;
    logic [7:0] r1_hmin, r1_hmax, r1_smin, r1_smax, r1_vmin, r1_vmax;
    logic       r1_hs, r1_vs, r1_de;
    // stage 2
    logic [7:0] r2_mask;
    logic       r2_hs, r2_vs, r2_de;
    // edge detection and coordinates
    logic           r_vs_d, r_de_d;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    // accumulators
    logic [CNT_W-1:0] r_acc_cnt;
    logic [X_W-1:0]   r_acc_x0, r_acc_x1;
    logic [Y_W-1:0]   r_acc_y0, r_acc_y1;
    // published statistics
    logic [CNT_W-1:0] r_cnt;
    logic [X_W-1:0]   r_bx0, r_bx1;
    logic [Y_W-1:0]   r_by0, r_by1;
    logic             r_bvalid, r_svalid;

    logic w_h_ok, w_s_ok, w_v_ok, w_skin;
    logic w_vs_rise, w_de_fall, w_pix_skin;

    // Stage 1: capture the pixel, its timing and the thresholds together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1_h    <= 8'h00;  r1_s    <= 8'h00;  r1_v    <= 8'h00;
            r1_hmin <= 8'h00;  r1_hmax <= 8'h00;
            r1_smin <= 8'h00;  r1_smax <= 8'h00;
            r1_vmin <= 8'h00;  r1_vmax <= 8'h00;
            r1_hs   <= 1'b0;   r1_vs   <= 1'b0;   r1_de   <= 1'b0;
        end else if (ce) begin
            r1_h    <= H;      r1_s    <= S;      r1_v    <= V;
            r1_hmin <= h_min;  r1_hmax <= h_max;
            r1_smin <= s_min;  r1_smax <= s_max;
            r1_vmin <= v_min;  r1_vmax <= v_max;
            r1_hs   <= in_hsync;
            r1_vs   <= in_vsync;
            r1_de   <= in_de;
        end
    end

    // Window compares; a hue window with min > max wraps through 0
    always_comb begin
        w_h_ok = 1'b0;
        if (r1_hmin <= r1_hmax) begin
            w_h_ok = (r1_h >= r1_hmin) && (r1_h <= r1_hmax);
        end else begin
            w_h_ok = (r1_h >= r1_hmin) || (r1_h <= r1_hmax);
        end
        // min > max makes these windows empty without any special case
        w_s_ok = (r1_s >= r1_smin) && (r1_s <= r1_smax);
        w_v_ok = (r1_v >= r1_vmin) && (r1_v <= r1_vmax);
        w_skin = w_h_ok && w_s_ok && w_v_ok && r1_de;
    end

    // Stage 2: register the mask (already gated by de) and the timing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_mask <= 8'h00;
            r2_hs   <= 1'b0;
            r2_vs   <= 1'b0;
            r2_de   <= 1'b0;
        end else if (ce) begin
            r2_mask <= w_skin ? 8'hFF : 8'h00;
            r2_hs   <= r1_hs;
            r2_vs   <= r1_vs;
            r2_de   <= r1_de;
        end
    end

    assign w_vs_rise  = r2_vs & ~r_vs_d;
    assign w_de_fall  = ~r2_de & r_de_d;
    assign w_pix_skin = r2_mask[0];

    // Coordinates of the pixel currently at the stage-2 output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= {X_W{1'b0}};
            r_y    <= {Y_W{1'b0}};
            r_vs_d <= 1'b0;
            r_de_d <= 1'b0;
        end else if (ce) begin
            r_vs_d <= r2_vs;
            r_de_d <= r2_de;
            if (w_vs_rise) begin
                r_x <= {X_W{1'b0}};
                r_y <= {Y_W{1'b0}};
            end else if (r2_de) begin
                r_x <= r_x + X_ONE;
            end else if (w_de_fall) begin
                r_x <= {X_W{1'b0}};
                r_y <= r_y + Y_ONE;
            end else begin
                r_x <= r_x;
                r_y <= r_y;
            end
        end
    end

    // Per-frame accumulators; emptied at the frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_cnt <= {CNT_W{1'b0}};
            r_acc_x0  <= {X_W{1'b1}};
            r_acc_x1  <= {X_W{1'b0}};
            r_acc_y0  <= {Y_W{1'b1}};
            r_acc_y1  <= {Y_W{1'b0}};
        end else if (ce) begin
            if (w_vs_rise) begin
                r_acc_cnt <= {CNT_W{1'b0}};
                r_acc_x0  <= {X_W{1'b1}};
                r_acc_x1  <= {X_W{1'b0}};
                r_acc_y0  <= {Y_W{1'b1}};
                r_acc_y1  <= {Y_W{1'b0}};
            end else if (w_pix_skin) begin
                if (r_acc_cnt != CNT_MAX) begin
                    r_acc_cnt <= r_acc_cnt + CNT_ONE;
                end
                if (r_x < r_acc_x0) r_acc_x0 <= r_x;
                if (r_x > r_acc_x1) r_acc_x1 <= r_x;
                if (r_y < r_acc_y0) r_acc_y0 <= r_y;
                if (r_y > r_acc_y1) r_acc_y1 <= r_y;
            end
        end
    end

    // Publish statistics at the frame boundary; empty frames report a zero box
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_bx0    <= {X_W{1'b0}};
            r_bx1    <= {X_W{1'b0}};
            r_by0    <= {Y_W{1'b0}};
            r_by1    <= {Y_W{1'b0}};
            r_bvalid <= 1'b0;
            r_svalid <= 1'b0;
        end else if (ce) begin
            r_svalid <= w_vs_rise;
            if (w_vs_rise) begin
                r_cnt <= r_acc_cnt;
                if (r_acc_cnt != {CNT_W{1'b0}}) begin
                    r_bx0    <= r_acc_x0;
                    r_bx1    <= r_acc_x1;
                    r_by0    <= r_acc_y0;
                    r_by1    <= r_acc_y1;
                    r_bvalid <= 1'b1;
                end else begin
                    r_bx0    <= {X_W{1'b0}};
                    r_bx1    <= {X_W{1'b0}};
                    r_by0    <= {Y_W{1'b0}};
                    r_by1    <= {Y_W{1'b0}};
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    assign mask        = r2_mask;
    assign out_hsync   = r2_hs;
    assign out_vsync   = r2_vs;
    assign out_de      = r2_de;
    assign skin_count  = r_cnt;
    assign bbox_x0     = r_bx0;
    assign bbox_x1     = r_bx1;
    assign bbox_y0     = r_by0;
    assign bbox_y1     = r_by1;
    assign bbox_valid  = r_bvalid;
    assign stats_valid = r_svalid;

endmodule
